muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit for the pipeline's execute stage. It generalises the team's sequential shift-add multiplier: same start/ready/done handshake and `m_signed` control, plus a `WIDTH` parameter and an `op` mode selecting multiply or restoring division. Division returns quotient and remainder together and flags divide-by-zero. Latency is fixed at `WIDTH+1` cycles for every operation, so the hazard unit can stall for a known number of cycles.

## Interface
- `WIDTH`, 32, operand width in bits; legal values are `WIDTH >= 2`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `ready=1`.
- `op`  in  1  operation: 0 = multiply, 1 = divide.
- `m_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `a`  in  WIDTH  multiplicand or dividend.
- `b`  in  WIDTH  multiplier or divisor.
- `ready`  out  1  unit is idle and will accept `start`.
- `done`  out  1  one-cycle pulse; `p` and `dz` are valid.
- `p`  out  2*WIDTH  result.
  - Multiply: full product.
  - Divide: `{remainder, quotient}`, remainder in the upper half.
- `dz`  out  1  divide-by-zero flag; valid when `done=1`.

## Operation
- **States:** IDLE → CALC → FIX → DONE → IDLE.
- **IDLE:** `ready=1`.
  - `start=1` at an edge latches `op` and `m_signed`.
  - It also latches |a| and |b|: absolute values if `m_signed=1`, otherwise the raw values. It records the result sign(s).
  - Clears `dz`, sets the counter to 0 and moves to CALC.
- **CALC:** one iteration per edge; the counter increments.
  - After the `WIDTH`th iteration, the state moves to FIX.
  - Multiply iteration: shift-add, LSB-first over |b|.
  - Divide iteration: restoring shift-subtract, MSB-first over |a|.
- **FIX:** applies sign correction and writes `p`.
  - Multiply: product is negated iff `m_signed` and `a[W-1]^b[W-1]`.
  - Divide: quotient is negated iff signs differ; remainder takes the sign of the dividend.
  - Sets `done=1` and moves to DONE.
- **DONE:** `done` drops and the state returns to IDLE with `ready=1`.
  - `p` and `dz` hold until the next accepted start, or until reset.
- **Divide by zero** (`b==0`, both signednesses):
  - quotient = all ones;
  - remainder = `a` unmodified;
  - `dz=1`.
- **Signed overflow** (`a` = most-negative, `b` = -1):
  - quotient = `a`, remainder = 0, `dz=0`.
  - Falls out of the magnitude datapath; no special case is required.
- **Width rules:**
  - Magnitudes of the most-negative value are computed in `WIDTH` bits unsigned (2^(W-1)).
  - Product accumulator: 2*WIDTH bits. Remainder accumulator: WIDTH+1 bits.
- **`start` while busy:** ignored. Operands may change freely after the accepting edge.

## Timing
- **Reset values:** `ready=1`, `done=0`, `dz=0`, `p=0`, state IDLE, counter 0.
  - Reset is asynchronous: it takes effect immediately, mid-operation included, and the result is discarded.
- **Latency:** let edge 0 be the edge at which `start` is accepted.
  - `ready` is low from edge 0 to edge `WIDTH+2`.
  - `done=1` and `p` are valid from edge `WIDTH+1` to edge `WIDTH+2`.
  - `ready=1` again after edge `WIDTH+2`.
- **Throughput:** the next start is accepted at edge `WIDTH+3` at the earliest. Back-to-back issue is therefore one op per `WIDTH+3` cycles.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **`start` held high:** holding `start` continuously issues a new operation each time `ready` returns. Each such issue uses the operands present at that edge.

## Test plan
- Signed multiply, `WIDTH=32`, `m_signed=1`: `a=32973`, `b=-492901` → `p=-16252424673` (64-bit two's complement).
  - `done` is asserted exactly 33 cycles after the start edge.
- Signed multiply with two negatives: `a=-971436`, `b=-78525` → `p=76282011900`.
  - Then unsigned: `a=45621`, `b=325401` → `p=14845119021`.
  - Issue both back-to-back with `start` held high; check `ready`/`done` spacing of 35 cycles.
- Signed divide: `a=-100`, `b=7` → quotient `-14` (`0xFFFFFFF2`), remainder `-2`, `dz=0`.
  - Unsigned divide: `a=0xFFFFFFFF`, `b=16` → quotient `0x0FFFFFFF`, remainder 15.
- Divide by zero: `a=123`, `b=0` → quotient `0xFFFFFFFF`, remainder 123, `dz=1`.
  - Follow with a multiply; `dz` must clear at the accepting edge.
  - Signed overflow: `a=0x80000000`, `b=-1` → quotient `0x80000000`, remainder 0.
- Reset mid-CALC: assert `reset` 10 cycles into a multiply.
  - Immediately `ready=1`, `done=0`, `p=0`, `dz=0`. No `done` pulse may follow.
  - A new start after reset produces the correct result.
- Parameter sweep at `WIDTH=8`: `a=-128`, `b=-128` signed → `p=16384`, `done` 9 cycles after start.
  - `a=200`, `b=0` unsigned divide → quotient `0xFF`, remainder 200, `dz=1`.

Source files
------------

// File: rtl/muldiv.sv
// Iterative multiply / restoring divide unit with a fixed WIDTH+1 cycle latency.
// Multiply yields the full 2*WIDTH product; divide yields {remainder, quotient} plus a divide-by-zero flag.
//
// state | meaning
// IDLE  | ready=1, waiting for start; latches operand magnitudes and sign info
// CALC  | WIDTH iterations of shift-add (mul) or shift-subtract (div)
// FIX   | sign correction, writes p and dz, pulses done
// DONE  | done drops, returns to IDLE with ready=1
module muldiv #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 op,
   input  logic                 m_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p,
   output logic                 dz
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_q;
   logic               neg_q;
   logic               neg_r_q;
   logic               dz_q;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   hi_nx;
   logic [WIDTH-1:0]   lo_nx;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] fix_p;

   // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
   always_comb begin
      abs_a = (m_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
      abs_b = (m_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
   end

   // Multiply: {hi,lo} starts as {0,|b|}; add |a| into hi when lo[0]=1, then shift right.
   // Divide: lo starts as |a| and collects quotient bits; hi is the running remainder.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_shift = {hi, lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      hi_nx     = hi;
      lo_nx     = lo;
      if (op_q) begin
         hi_nx = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], div_ge};
      end else begin
         hi_nx = mul_sum[WIDTH:1];
         lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      mul_res = {hi, lo};
      quo_fix = dz_q ? {WIDTH{1'b1}} : (neg_q ? (WIDTH'(0) - lo) : lo);
      rem_fix = neg_r_q ? (WIDTH'(0) - hi) : hi;
      fix_p   = op_q ? {rem_fix, quo_fix}
                     : (neg_q ? ((2*WIDTH)'(0) - mul_res) : mul_res);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         opnd    <= '0;
         hi      <= '0;
         lo      <= '0;
         ready   <= 1'b1;
         done    <= 1'b0;
         p       <= '0;
         dz      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  neg_q   <= m_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_q <= m_signed & a[WIDTH-1];
                  dz_q    <= op & (b == '0);
                  opnd    <= op ? abs_b : abs_a;
                  hi      <= '0;
                  lo      <= op ? abs_a : abs_b;
                  cnt     <= '0;
                  dz      <= 1'b0;
                  ready   <= 1'b0;
                  state   <= CALC;
               end
            end
            CALC: begin
               hi  <= hi_nx;
               lo  <= lo_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               p     <= fix_p;
               dz    <= dz_q;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv at WIDTH=32 and WIDTH=8: expected results queued at issue,
// compared (value, dz, latency) when done pulses.
module tb_muldiv;

   typedef struct {
      logic [63:0] p;
      logic        dz;
      time         t;
   } exp_t;

   logic        clk;
   logic        rst;

   logic        start32, op32, sg32;
   logic [31:0] a32, b32;
   logic        ready32, done32, dz32;
   logic [63:0] p32;

   logic        start8, op8, sg8;
   logic [7:0]  a8, b8;
   logic        ready8, done8, dz8;
   logic [15:0] p8;

   exp_t q32[$];
   exp_t q8[$];
   exp_t e32, e8;
   time  last_done, prev_done;
   int   n_chk;
   int   n_fail;

   muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst), .start(start32), .op(op32), .m_signed(sg32),
      .a(a32), .b(b32), .ready(ready32), .done(done32), .p(p32), .dz(dz32)
   );

   muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst), .start(start8), .op(op8), .m_signed(sg8),
      .a(a8), .b(b8), .ready(ready8), .done(done8), .p(p8), .dz(dz8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done32) begin
         if (q32.size() == 0) begin
            check("spurious_done32", 64'(done32), 64'd0);
         end else begin
            e32 = q32.pop_front();
            check("p32", p32, e32.p);
            check("dz32", 64'(dz32), 64'(e32.dz));
            check("lat32", 64'(($time - e32.t - 5) / 10), 64'd33);
            prev_done = last_done;
            last_done = $time;
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            check("spurious_done8", 64'(done8), 64'd0);
         end else begin
            e8 = q8.pop_front();
            check("p8", 64'(p8), e8.p);
            check("dz8", 64'(dz8), 64'(e8.dz));
            check("lat8", 64'(($time - e8.t - 5) / 10), 64'd9);
         end
      end
   end

   task automatic issue32(input logic o, input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] ep, input logic edz, input logic hold, output time t_acc);
      logic acc;
      exp_t x;
      @(negedge clk);
      op32 = o; sg32 = s; a32 = av; b32 = bv; start32 = 1'b1;
      acc = 1'b0;
      t_acc = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (ready32) begin
            acc = 1'b1;
            break;
         end
      end
      check("accept32", 64'(acc), 64'd1);
      t_acc = $time;
      x.p = ep; x.dz = edz; x.t = $time;
      if (acc) q32.push_back(x);
      if (!hold) begin
         @(negedge clk);
         start32 = 1'b0;
      end
   endtask

   task automatic issue8(input logic o, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] ep, input logic edz);
      logic acc;
      exp_t x;
      @(negedge clk);
      op8 = o; sg8 = s; a8 = av; b8 = bv; start8 = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         if (ready8) begin
            acc = 1'b1;
            break;
         end
      end
      check("accept8", 64'(acc), 64'd1);
      x.p = 64'(ep); x.dz = edz; x.t = $time;
      if (acc) q8.push_back(x);
      @(negedge clk);
      start8 = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (q32.size() > 0 || q8.size() > 0); k++)
         @(negedge clk);
      check("drain32", 64'(q32.size()), 64'd0);
      check("drain8", 64'(q8.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      time t1, t2, td1;
      logic [31:0] ra, rb;
      logic        rs;
      logic [63:0] ep;
      n_chk = 0; n_fail = 0;
      last_done = 0; prev_done = 0;
      rst = 1'b1;
      start32 = 1'b0; op32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
      start8 = 1'b0; op8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
      @(negedge clk);
      check("rst_ready", 64'(ready32), 64'd1);
      check("rst_done", 64'(done32), 64'd0);
      check("rst_p", p32, 64'd0);
      check("rst_dz", 64'(dz32), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      issue32(1'b0, 1'b1, 32'd32973, -32'sd492901, -64'sd16252424673, 1'b0, 1'b0, t1);
      drain();

      issue32(1'b0, 1'b1, -32'sd971436, -32'sd78525, 64'd76282011900, 1'b0, 1'b1, t1);
      td1 = 0;
      issue32(1'b0, 1'b0, 32'd45621, 32'd325401, 64'd14845119021, 1'b0, 1'b0, t2);
      check("b2b_accept_gap", 64'((t2 - t1) / 10), 64'd35);
      drain();
      td1 = last_done - prev_done;
      check("b2b_done_gap", 64'(td1 / 10), 64'd35);

      issue32(1'b1, 1'b1, -32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 1'b0, t1);
      issue32(1'b1, 1'b0, 32'hFFFFFFFF, 32'd16, {32'd15, 32'h0FFFFFFF}, 1'b0, 1'b0, t1);
      issue32(1'b1, 1'b0, 32'd123, 32'd0, {32'd123, 32'hFFFFFFFF}, 1'b1, 1'b0, t1);
      drain();
      check("dz_held", 64'(dz32), 64'd1);
      issue32(1'b0, 1'b0, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, t1);
      check("dz_cleared", 64'(dz32), 64'd0);
      check("busy_ready", 64'(ready32), 64'd0);
      issue32(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 1'b0, t1);
      issue32(1'b1, 1'b1, -32'sd5, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1'b0, t1);
      drain();

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i % 2 == 0) begin
            ep = rs ? ({{32{ra[31]}}, ra} * {{32{rb[31]}}, rb}) : ({32'b0, ra} * {32'b0, rb});
            issue32(1'b0, rs, ra, rb, ep, 1'b0, 1'b0, t1);
         end else begin
            if (rb == 32'd0 || rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rs)
               ep = {32'($signed(ra) % $signed(rb)), 32'($signed(ra) / $signed(rb))};
            else
               ep = {ra % rb, ra / rb};
            issue32(1'b1, rs, ra, rb, ep, 1'b0, 1'b0, t1);
         end
      end
      drain();

      issue32(1'b0, 1'b1, 32'd1000, 32'd1000, 64'd1000000, 1'b0, 1'b0, t1);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ready", 64'(ready32), 64'd1);
      check("midrst_done", 64'(done32), 64'd0);
      check("midrst_p", p32, 64'd0);
      check("midrst_dz", 64'(dz32), 64'd0);
      q32.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      issue32(1'b0, 1'b1, -32'sd7, 32'd9, -64'sd63, 1'b0, 1'b0, t1);
      drain();

      issue8(1'b0, 1'b1, 8'h80, 8'h80, 16'd16384, 1'b0);
      issue8(1'b1, 1'b0, 8'd200, 8'd0, {8'd200, 8'hFF}, 1'b1);
      issue8(1'b1, 1'b1, -8'sd100, 8'd7, {8'hFE, 8'hF2}, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
